// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and sizes for the decode-stage hazard controller
package hazard_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } hz_state_t;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write tracking with two hazard lookup ports
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 setEn,
    input  logic [REG_IDX_W-1:0] setIdx,
    input  logic                 setLd,
    input  logic                 clrEn,
    input  logic [REG_IDX_W-1:0] clrIdx,
    input  logic [REG_IDX_W-1:0] rs1Idx,
    input  logic                 rs1Used,
    input  logic [REG_IDX_W-1:0] rs2Idx,
    input  logic                 rs2Used,
    output logic                 rs1Hz,
    output logic                 rs2Hz
);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pendLd;

    // A write-back landing this cycle already resolves the source, so it never hazards.
    assign rs1Hz = rs1Used && (rs1Idx != '0) && pend[rs1Idx]
                   && !(clrEn && (clrIdx == rs1Idx))
                   && (!FORWARD_EN || pendLd[rs1Idx]);
    assign rs2Hz = rs2Used && (rs2Idx != '0) && pend[rs2Idx]
                   && !(clrEn && (clrIdx == rs2Idx))
                   && (!FORWARD_EN || pendLd[rs2Idx]);

    // Set is written after clear so a same-index collision leaves the entry pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend   <= '0;
            pendLd <= '0;
        end else begin
            if (clrEn) begin
                pend[clrIdx]   <= 1'b0;
                pendLd[clrIdx] <= 1'b0;
            end
            if (setEn && (setIdx != '0)) begin
                pend[setIdx]   <= 1'b1;
                pendLd[setIdx] <= setLd;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-side pipeline sequencer: RAW/load-use stalls, mul/div hold, branch flush
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 id_multicycle,
    input  logic                 ex_done,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 branch_taken,
    output logic                 issue,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 flush_if,
    output logic                 flush_id,
    output logic                 mc_timeout_err,
    output logic [CNT_W-1:0]     stall_cycles
);

    localparam logic [7:0]       MC_LIMIT  = 8'(MC_TIMEOUT);
    localparam logic [7:0]       MC_LAST   = 8'(MC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);

    hz_state_t        state;
    logic [7:0]       mcCnt;
    logic             errReg;
    logic [CNT_W-1:0] stallCnt;
    logic             rs1Hz;
    logic             rs2Hz;

    reg_scoreboard #(.FORWARD_EN(FORWARD_EN)) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .setEn   (issue && id_reg_write),
        .setIdx  (id_rd),
        .setLd   (id_mem_read),
        .clrEn   (wb_valid),
        .clrIdx  (wb_rd),
        .rs1Idx  (id_rs1),
        .rs1Used (id_rs1_used),
        .rs2Idx  (id_rs2),
        .rs2Used (id_rs2_used),
        .rs1Hz   (rs1Hz),
        .rs2Hz   (rs2Hz)
    );

    always_comb begin
        issue    = 1'b0;
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_if = 1'b0;
        flush_id = 1'b0;
        if (reset) begin
            flush_id = 1'b1;
        end else if (branch_taken) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else if (id_valid && (rs1Hz || rs2Hz || (state == MC_BUSY))) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_id = 1'b1;
        end else begin
            issue = id_valid;
        end
    end

    assign mc_timeout_err = errReg;
    assign stall_cycles   = stallCnt;

    // Once timed out the unit is considered hung: only reset releases MC_BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mcCnt    <= '0;
            errReg   <= 1'b0;
            stallCnt <= '0;
        end else begin
            if (stall_id && (stallCnt != '1)) begin
                stallCnt <= stallCnt + STALL_ONE;
            end
            if (state == IDLE) begin
                if (issue && id_multicycle) begin
                    state <= MC_BUSY;
                    mcCnt <= '0;
                end
            end else if (ex_done && !errReg) begin
                state <= IDLE;
            end else if (mcCnt != MC_LIMIT) begin
                mcCnt <= mcCnt + 8'd1;
                if (mcCnt == MC_LAST) begin
                    errReg <= 1'b1;
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(branch_taken && (state == MC_BUSY)));

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (forwarding and non-forwarding instances)
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, id_multicycle;
    logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic       ex_done, wb_valid, branch_taken;

    logic        oIssue[2], oStallIf[2], oStallId[2], oFlushIf[2], oFlushId[2], oErr[2];
    logic [31:0] oStallCnt[2];

    int checks = 0;
    int errors = 0;

    // index 0: FORWARD_EN=1, MC_TIMEOUT=8; index 1: FORWARD_EN=0, MC_TIMEOUT=64
    bit          mPend[2][32];
    bit          mLd[2][32];
    bit          mBusy[2];
    int          mCnt[2];
    bit          mErr[2];
    logic [31:0] mStall[2];

    always #5 clk = ~clk;

    hazard_ctrl #(.FORWARD_EN(1'b1), .MC_TIMEOUT(8), .CNT_W(32)) dutFwd (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_multicycle(id_multicycle),
        .ex_done(ex_done), .wb_valid(wb_valid), .wb_rd(wb_rd), .branch_taken(branch_taken),
        .issue(oIssue[0]), .stall_if(oStallIf[0]), .stall_id(oStallId[0]),
        .flush_if(oFlushIf[0]), .flush_id(oFlushId[0]), .mc_timeout_err(oErr[0]),
        .stall_cycles(oStallCnt[0])
    );

    hazard_ctrl #(.FORWARD_EN(1'b0), .MC_TIMEOUT(64), .CNT_W(32)) dutNoFwd (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_multicycle(id_multicycle),
        .ex_done(ex_done), .wb_valid(wb_valid), .wb_rd(wb_rd), .branch_taken(branch_taken),
        .issue(oIssue[1]), .stall_if(oStallIf[1]), .stall_id(oStallId[1]),
        .flush_if(oFlushIf[1]), .flush_id(oFlushId[1]), .mc_timeout_err(oErr[1]),
        .stall_cycles(oStallCnt[1])
    );

    // control vector order: {issue, stall_if, stall_id, flush_if, flush_id}
    function automatic logic [4:0] ctlVec(input int c);
        return {oIssue[c], oStallIf[c], oStallId[c], oFlushIf[c], oFlushId[c]};
    endfunction

    function automatic bit srcHz(input int c, input logic [4:0] s, input logic used);
        if (!used || s == 5'd0 || !mPend[c][s]) return 1'b0;
        if (wb_valid && wb_rd == s) return 1'b0;
        if (c == 0 && !mLd[c][s]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [4:0] expCtl(input int c);
        bit hz;
        hz = srcHz(c, id_rs1, id_rs1_used) || srcHz(c, id_rs2, id_rs2_used);
        if (reset) return 5'b00001;
        if (branch_taken) return 5'b00011;
        if (id_valid && (hz || mBusy[c])) return 5'b01101;
        return {id_valid, 4'b0000};
    endfunction

    task automatic modelEdge();
        for (int c = 0; c < 2; c++) begin
            logic [4:0] e;
            int tmo;
            e = expCtl(c);
            tmo = (c == 0) ? 8 : 64;
            if (reset) begin
                for (int r = 0; r < 32; r++) begin
                    mPend[c][r] = 1'b0;
                    mLd[c][r] = 1'b0;
                end
                mBusy[c] = 1'b0; mCnt[c] = 0; mErr[c] = 1'b0; mStall[c] = '0;
            end else begin
                if (e[2] && mStall[c] != 32'hFFFF_FFFF) mStall[c] = mStall[c] + 1;
                if (wb_valid) begin
                    mPend[c][wb_rd] = 1'b0;
                    mLd[c][wb_rd] = 1'b0;
                end
                if (e[4] && id_reg_write && id_rd != 5'd0) begin
                    mPend[c][id_rd] = 1'b1;
                    mLd[c][id_rd] = id_mem_read;
                end
                if (!mBusy[c]) begin
                    if (e[4] && id_multicycle) begin
                        mBusy[c] = 1'b1;
                        mCnt[c] = 0;
                    end
                end else if (ex_done && !mErr[c]) begin
                    mBusy[c] = 1'b0;
                end else begin
                    if (mCnt[c] < tmo) mCnt[c]++;
                    if (mCnt[c] == tmo) mErr[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIns();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; id_multicycle = 0;
        ex_done = 0; wb_valid = 0; wb_rd = 0; branch_taken = 0;
    endtask

    task automatic setIns(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic rw,
                          input logic ld, input logic mc);
        id_valid = 1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = ld; id_multicycle = mc;
    endtask

    task automatic doReset();
        clearIns();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        clearIns();
        reset = 1;
        setIns(5'd3, 1, 5'd4, 1, 5'd6, 1, 1, 1);
        branch_taken = 1;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ctlVec(c) !== 5'b00001) begin
                errors++;
                $display("FAIL reset_ctl dut%0d got=%b exp=00001", c, ctlVec(c));
            end
        end
        tick();
        reset = 0;
        clearIns();
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (oStallCnt[c] !== 32'd0 || oErr[c] !== 1'b0 || ctlVec(c) !== 5'b00000) begin
                errors++;
                $display("FAIL reset_state dut%0d got cnt=%0d err=%b ctl=%b exp 0/0/00000",
                         c, oStallCnt[c], oErr[c], ctlVec(c));
            end
        end
        tick();
    endtask

    task automatic test_load_use();
        doReset();
        setIns(5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ctlVec(c) !== 5'b10000) begin errors++; $display("FAIL ld_issue dut%0d got=%b exp=10000", c, ctlVec(c)); end
        end
        tick();
        setIns(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ctlVec(c) !== 5'b01101) begin errors++; $display("FAIL load_use_stall dut%0d got=%b exp=01101", c, ctlVec(c)); end
        end
        tick();
        wb_valid = 1; wb_rd = 5'd5;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ctlVec(c) !== 5'b10000) begin errors++; $display("FAIL wb_bypass_issue dut%0d got=%b exp=10000", c, ctlVec(c)); end
        end
        tick();
        clearIns();
        setIns(5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ctlVec(c) !== 5'b10000 || oStallCnt[c] !== 32'd1) begin
                errors++;
                $display("FAIL x5_cleared dut%0d got ctl=%b cnt=%0d exp ctl=10000 cnt=1", c, ctlVec(c), oStallCnt[c]);
            end
        end
        tick();
    endtask

    task automatic test_forward();
        doReset();
        setIns(5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0);
        tick();
        setIns(5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ctlVec(0) !== 5'b10000) begin errors++; $display("FAIL fwd_no_stall k=%0d got=%b exp=10000", k, ctlVec(0)); end
            checks++;
            if (ctlVec(1) !== 5'b01101) begin errors++; $display("FAIL nofwd_stall k=%0d got=%b exp=01101", k, ctlVec(1)); end
            tick();
        end
        wb_valid = 1; wb_rd = 5'd7;
        @(negedge clk);
        checks++;
        if (ctlVec(1) !== 5'b10000) begin errors++; $display("FAIL nofwd_release got=%b exp=10000", ctlVec(1)); end
        tick();
        clearIns();
    endtask

    task automatic test_multicycle();
        int n;
        doReset();
        n = $urandom_range(2, 6);
        setIns(5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 1);
        ex_done = 1;
        tick();
        ex_done = 0;
        setIns(5'd1, 1, 5'd2, 1, 5'd10, 1, 0, 0);
        for (int k = 1; k <= n; k++) begin
            ex_done = (k == n);
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (ctlVec(c) !== 5'b01101) begin errors++; $display("FAIL mc_stall dut%0d k=%0d got=%b exp=01101", c, k, ctlVec(c)); end
            end
            tick();
        end
        ex_done = 0;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ctlVec(c) !== 5'b10000 || oStallCnt[c] !== 32'(n)) begin
                errors++;
                $display("FAIL mc_release dut%0d got ctl=%b cnt=%0d exp ctl=10000 cnt=%0d", c, ctlVec(c), oStallCnt[c], n);
            end
        end
        tick();
        clearIns();
    endtask

    task automatic test_branch();
        doReset();
        setIns(5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);
        tick();
        setIns(5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);
        branch_taken = 1;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ctlVec(c) !== 5'b00011) begin errors++; $display("FAIL branch_flush dut%0d got=%b exp=00011", c, ctlVec(c)); end
        end
        tick();
        branch_taken = 0;
        setIns(5'd6, 1, 5'd0, 0, 5'd0, 0, 0, 0);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ctlVec(c) !== 5'b10000) begin errors++; $display("FAIL squashed_rd_clear dut%0d got=%b exp=10000", c, ctlVec(c)); end
        end
        tick();
        clearIns();
    endtask

    task automatic test_x0_collision();
        doReset();
        setIns(5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0);
        tick();
        setIns(5'd0, 1, 5'd0, 1, 5'd4, 1, 0, 0);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ctlVec(c) !== 5'b10000) begin errors++; $display("FAIL x0_no_hazard dut%0d got=%b exp=10000", c, ctlVec(c)); end
        end
        tick();
        setIns(5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 0);
        tick();
        wb_valid = 1; wb_rd = 5'd3;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ctlVec(c) !== 5'b10000) begin errors++; $display("FAIL collision_issue dut%0d got=%b exp=10000", c, ctlVec(c)); end
        end
        tick();
        clearIns();
        setIns(5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ctlVec(c) !== 5'b01101) begin errors++; $display("FAIL collision_set_wins dut%0d got=%b exp=01101", c, ctlVec(c)); end
        end
        tick();
        clearIns();
    endtask

    task automatic test_reset_mid_mc();
        doReset();
        setIns(5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 1);
        tick();
        setIns(5'd1, 1, 5'd0, 0, 5'd11, 1, 0, 0);
        repeat (10) tick();
        @(negedge clk);
        checks++;
        if (oErr[0] !== 1'b1 || oErr[1] !== 1'b0) begin
            errors++;
            $display("FAIL err_before_reset got fwd=%b nofwd=%b exp 1/0", oErr[0], oErr[1]);
        end
        reset = 1;
        tick();
        reset = 0;
        clearIns();
        setIns(5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 0);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ctlVec(c) !== 5'b10000 || oStallCnt[c] !== 32'd0 || oErr[c] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset dut%0d got ctl=%b cnt=%0d err=%b exp 10000/0/0", c, ctlVec(c), oStallCnt[c], oErr[c]);
            end
        end
        tick();
        clearIns();
    endtask

    task automatic test_timeout();
        doReset();
        setIns(5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 1);
        tick();
        setIns(5'd1, 1, 5'd0, 0, 5'd12, 1, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (oErr[0] !== (k >= 8)) begin
                errors++;
                $display("FAIL timeout_err k=%0d got=%b exp=%b", k, oErr[0], (k >= 8));
            end
        end
        ex_done = 1;
        tick();
        ex_done = 0;
        @(negedge clk);
        checks++;
        if (ctlVec(0) !== 5'b01101 || ctlVec(1) !== 5'b10000) begin
            errors++;
            $display("FAIL timeout_stuck got fwd=%b nofwd=%b exp 01101/10000", ctlVec(0), ctlVec(1));
        end
        tick();
        doReset();
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 99) < 2);
            id_valid      = ($urandom_range(0, 3) != 0);
            id_rs1        = 5'($urandom_range(0, 7));
            id_rs2        = 5'($urandom_range(0, 7));
            id_rs1_used   = $urandom_range(0, 1);
            id_rs2_used   = $urandom_range(0, 1);
            id_rd         = 5'($urandom_range(0, 7));
            id_reg_write  = ($urandom_range(0, 9) < 7);
            id_mem_read   = ($urandom_range(0, 9) < 4);
            id_multicycle = ($urandom_range(0, 9) == 0);
            ex_done       = ($urandom_range(0, 9) < 3);
            wb_valid      = ($urandom_range(0, 9) < 4);
            wb_rd         = 5'($urandom_range(0, 7));
            branch_taken  = !mBusy[0] && !mBusy[1] && ($urandom_range(0, 99) < 8);
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (ctlVec(c) !== expCtl(c)) begin
                    errors++;
                    $display("FAIL rand_ctl dut%0d i=%0d got=%b exp=%b", c, i, ctlVec(c), expCtl(c));
                end
                checks++;
                if (oStallCnt[c] !== mStall[c] || oErr[c] !== mErr[c]) begin
                    errors++;
                    $display("FAIL rand_cnt_err dut%0d i=%0d got cnt=%0d err=%b exp cnt=%0d err=%b",
                             c, i, oStallCnt[c], oErr[c], mStall[c], mErr[c]);
                end
            end
            tick();
        end
        clearIns();
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clearIns();
        reset = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_forward();
        test_multicycle();
        test_branch();
        test_x0_collision();
        test_reset_mid_mc();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
